// File: rtl/fcvt_wu_s_iter.sv
// fcvt_wu_s_iter: iterative IEEE-754 single -> unsigned 32-bit converter (FCVT.WU.S).
// The magnitude is aligned one bit per cycle, then rounded in a single step.
// Ports:
//   clk     - clock, rising edge
//   resetn  - asynchronous reset, active-high (1 = reset)
//   start   - conversion request, sampled only while busy=0
//   rs1     - IEEE-754 single operand
//   rm      - rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE)
//   out     - unsigned result, held until the next completion
//   fflags  - {NV,DZ,OF,UF,NX}; only NV and NX are ever set
//   valid   - one-cycle pulse, out/fflags are valid
//   busy    - high from the accept edge through the valid cycle
module fcvt_wu_s_iter #(
  parameter int unsigned RSHIFT_CAP = 25
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] rs1,
  input  logic [2:0]  rm,
  output logic [31:0] out,
  output logic [4:0]  fflags,
  output logic        valid,
  output logic        busy
);

  // Count must hold both the capped right shift and the 8-step left shift.
  localparam int unsigned CAP_BITS = $clog2(RSHIFT_CAP + 1);
  localparam int unsigned CNT_W    = (CAP_BITS > 4) ? CAP_BITS : 4;
  localparam logic signed [9:0] CAP_S = 10'(RSHIFT_CAP);

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  state_t            state, state_d;
  logic              sign_q, sign_d;
  logic [2:0]        rm_q, rm_d;
  logic [31:0]       mag_q, mag_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              left_q, left_d;
  logic              forced_q, forced_d;
  logic              forced_nv_q, forced_nv_d;
  logic [31:0]       forced_val_q, forced_val_d;
  logic [31:0]       res_q, res_d;
  logic [4:0]        res_flags_q, res_flags_d;
  logic [31:0]       out_d;
  logic [4:0]        fflags_d;
  logic              valid_d;
  logic              busy_d;

  // Operand decode
  logic [7:0]        exp_f;
  logic [22:0]       frac_f;
  logic              sgn_f;
  logic              is_nan, is_inf, is_zero;
  logic signed [9:0] e_unb;
  logic signed [9:0] rsh;
  logic signed [9:0] rsh_cap;
  logic [CNT_W-1:0]  lsh;

  assign exp_f   = rs1[30:23];
  assign frac_f  = rs1[22:0];
  assign sgn_f   = rs1[31];
  assign is_nan  = (exp_f == 8'hFF) && (frac_f != 23'd0);
  assign is_inf  = (exp_f == 8'hFF) && (frac_f == 23'd0);
  assign is_zero = (exp_f == 8'd0) && (frac_f == 23'd0);
  // Denormals share the minimum normal exponent.
  assign e_unb   = (exp_f == 8'd0) ? -10'sd126 : ($signed({2'b00, exp_f}) - 10'sd127);
  assign rsh     = 10'sd23 - e_unb;
  assign rsh_cap = (rsh > CAP_S) ? CAP_S : rsh;
  assign lsh     = CNT_W'(e_unb - 10'sd23);

  // Rounding increment and inexact from the aligned magnitude
  logic        inc, inexact;
  logic [31:0] sum;

  always_comb begin
    inexact = guard_q | sticky_q;
    inc     = 1'b0;
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_q & inexact;
      3'b011:  inc = ~sign_q & inexact;
      3'b100:  inc = guard_q;
      default: inc = guard_q & (sticky_q | mag_q[0]);
    endcase
  end

  // Carry-out cannot occur: only e<=31 reaches here and those are exact.
  assign sum = mag_q + 32'(inc);

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d      = state;
    sign_d       = sign_q;
    rm_d         = rm_q;
    mag_d        = mag_q;
    guard_d      = guard_q;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;
    left_d       = left_q;
    forced_d     = forced_q;
    forced_nv_d  = forced_nv_q;
    forced_val_d = forced_val_q;
    res_d        = res_q;
    res_flags_d  = res_flags_q;
    out_d        = out;
    fflags_d     = fflags;
    valid_d      = 1'b0;
    busy_d       = busy;

    case (state)
      IDLE: begin
        // busy is still high during the valid cycle, which blocks accept there.
        busy_d = 1'b0;
        if (start && !busy) begin
          busy_d       = 1'b1;
          sign_d       = sgn_f;
          rm_d         = rm;
          mag_d        = {8'd0, (exp_f != 8'd0), frac_f};
          guard_d      = 1'b0;
          sticky_d     = 1'b0;
          cnt_d        = '0;
          left_d       = 1'b0;
          forced_d     = 1'b0;
          forced_nv_d  = 1'b0;
          forced_val_d = 32'd0;
          state_d      = ROUND;
          if (is_nan || (!sgn_f && (is_inf || e_unb >= 10'sd32))) begin
            forced_d     = 1'b1;
            forced_nv_d  = 1'b1;
            forced_val_d = 32'hFFFF_FFFF;
          end else if (sgn_f && (is_inf || e_unb >= 10'sd0)) begin
            forced_d    = 1'b1;
            forced_nv_d = 1'b1;
          end else if (is_zero) begin
            forced_d = 1'b1;
          end else if (e_unb >= 10'sd23) begin
            left_d  = 1'b1;
            cnt_d   = lsh;
            state_d = (lsh == '0) ? ROUND : ALIGN;
          end else begin
            cnt_d   = CNT_W'(rsh_cap);
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (left_q) begin
          mag_d = {mag_q[30:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[31:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ROUND;
      end

      ROUND: begin
        state_d = DONE;
        if (forced_q) begin
          res_d       = forced_val_q;
          res_flags_d = {forced_nv_q, 4'b0000};
        end else if (!sign_q) begin
          res_d       = sum;
          res_flags_d = {4'b0000, inexact};
        end else if (sum == 32'd0) begin
          res_d       = 32'd0;
          res_flags_d = {4'b0000, inexact};
        end else begin
          res_d       = 32'd0;
          res_flags_d = 5'b10000;
        end
      end

      DONE: begin
        out_d    = res_q;
        fflags_d = res_flags_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sign_q       <= 1'b0;
      rm_q         <= 3'd0;
      mag_q        <= 32'd0;
      guard_q      <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
      left_q       <= 1'b0;
      forced_q     <= 1'b0;
      forced_nv_q  <= 1'b0;
      forced_val_q <= 32'd0;
      res_q        <= 32'd0;
      res_flags_q  <= 5'd0;
      out          <= 32'd0;
      fflags       <= 5'd0;
      valid        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sign_q       <= sign_d;
      rm_q         <= rm_d;
      mag_q        <= mag_d;
      guard_q      <= guard_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
      left_q       <= left_d;
      forced_q     <= forced_d;
      forced_nv_q  <= forced_nv_d;
      forced_val_q <= forced_val_d;
      res_q        <= res_d;
      res_flags_q  <= res_flags_d;
      out          <= out_d;
      fflags       <= fflags_d;
      valid        <= valid_d;
      busy         <= busy_d;
    end
  end

endmodule
